// File: rtl/juego_pkg.sv
// ============================================================
//  juego_pkg : 2048 board types, direction codes, FSM states
//  Rev 1.0
// ============================================================
`default_nettype none

package juego_pkg;

    localparam int TAM_TAB = 4;

    typedef int tablero_t [TAM_TAB][TAM_TAB];
    typedef int linea_t [TAM_TAB];

    localparam logic [2:0] DIR_IZQ  = 3'b001;
    localparam logic [2:0] DIR_DER  = 3'b010;
    localparam logic [2:0] DIR_ARR  = 3'b011;
    localparam logic [2:0] DIR_ABA  = 3'b100;
    localparam logic [2:0] DIR_NADA = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CARGA    = 2'd1,
        PROCESAR = 2'd2,
        FIN      = 2'd3
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/mover_tablero_if.sv
// ============================================================
//  mover_tablero_if : move request / result bundle
//  Rev 1.0
// ============================================================
`default_nettype none

interface mover_tablero_if;
    import juego_pkg::*;

    logic        inicio;
    logic [2:0]  direccion;
    tablero_t    matriz_entrada;
    tablero_t    matriz_resultante;
    logic [2:0]  selector;
    logic        listo;
    logic        ocupado;
    logic        movido;
    logic [31:0] puntos;
    logic        gano;

    modport master (
        output inicio, direccion, matriz_entrada,
        input  matriz_resultante, selector, listo, ocupado, movido, puntos, gano
    );

    modport slave (
        input  inicio, direccion, matriz_entrada,
        output matriz_resultante, selector, listo, ocupado, movido, puntos, gano
    );

endinterface

`default_nettype wire

// File: rtl/mover_tablero_comprimir_linea.sv
// ============================================================
//  comprimir_linea : slide and merge one line toward index 0
//  Rev 1.0
// ============================================================
`default_nettype none

module comprimir_linea
    import juego_pkg::*;
(
    input  linea_t      linea_i,
    output linea_t      linea_o,
    output logic [31:0] puntos_o
);

    localparam int NW = $clog2(TAM_TAB + 1);
    localparam int JW = $clog2(TAM_TAB);

    // One spare zero slot so the pairwise look-ahead never leaves the array
    int            compacta [TAM_TAB+1];
    logic [NW-1:0] n;
    logic [JW-1:0] j;
    logic          salta;

    always_comb begin
        compacta = '{default: 0};
        linea_o  = '{default: 0};
        n        = '0;
        j        = '0;
        salta    = 1'b0;
        puntos_o = '0;

        for (int i = 0; i < TAM_TAB; i++) begin
            if (linea_i[i] != 0) begin
                compacta[n] = linea_i[i];
                n           = n + 1'b1;
            end
        end

        for (int i = 0; i < TAM_TAB; i++) begin
            if (salta) begin
                salta = 1'b0;
            end else if (compacta[i] != 0) begin
                if (compacta[i] == compacta[i+1]) begin
                    linea_o[j] = compacta[i] + compacta[i];
                    puntos_o   = puntos_o + 32'(compacta[i] + compacta[i]);
                    salta      = 1'b1;
                end else begin
                    linea_o[j] = compacta[i];
                end
                j = j + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mover_tablero.sv
// ============================================================
//  mover_tablero : 2048 move/merge stage, one line per cycle
//  Rev 1.0
// ============================================================
`default_nettype none

module mover_tablero
    import juego_pkg::*;
#(
    parameter int TAM  = TAM_TAB,
    parameter int META = 2048
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mover_tablero_if.slave bus
);

    localparam int            KW    = $clog2(TAM);
    localparam logic [KW-1:0] K_ULT = KW'(TAM - 1);

    estado_t       estado_q, estado_d;
    logic [KW-1:0] k_q, k_d;
    logic [2:0]    dir_q, dir_d;
    tablero_t      tablero_q, tablero_d;
    tablero_t      original_q, original_d;
    logic [31:0]   puntos_q, puntos_d;

    tablero_t      res_q;
    logic [2:0]    sel_q;
    logic          movido_q;
    logic          gano_q;
    logic [31:0]   puntos_out_q;

    linea_t        linea_w, linea_res_w;
    logic [31:0]   puntos_linea_w;
    logic          movido_w, gano_w, dir_valida_w;
    logic [2:0]    sel_w;

    assign dir_valida_w = (dir_q == DIR_IZQ) || (dir_q == DIR_DER) ||
                          (dir_q == DIR_ARR) || (dir_q == DIR_ABA);

    always_comb begin
        estado_d = estado_q;
        k_d      = k_q;
        case (estado_q)
            IDLE:     if (bus.inicio) estado_d = CARGA;
            CARGA: begin
                k_d      = '0;
                estado_d = dir_valida_w ? PROCESAR : FIN;
            end
            PROCESAR: begin
                k_d = k_q + 1'b1;
                if (k_q == K_ULT) estado_d = FIN;
            end
            FIN:      estado_d = IDLE;
            default:  estado_d = IDLE;
        endcase
    end

    // Line k is read front-to-back in the move direction and written back the same way
    always_comb begin
        linea_w = '{default: 0};
        for (int i = 0; i < TAM; i++) begin
            case (dir_q)
                DIR_IZQ: linea_w[i] = tablero_q[k_q][i];
                DIR_DER: linea_w[i] = tablero_q[k_q][TAM-1-i];
                DIR_ARR: linea_w[i] = tablero_q[i][k_q];
                DIR_ABA: linea_w[i] = tablero_q[TAM-1-i][k_q];
                default: linea_w[i] = 0;
            endcase
        end
    end

    comprimir_linea u_comprimir (
        .linea_i  (linea_w),
        .linea_o  (linea_res_w),
        .puntos_o (puntos_linea_w)
    );

    always_comb begin
        tablero_d  = tablero_q;
        original_d = original_q;
        dir_d      = dir_q;
        puntos_d   = puntos_q;
        case (estado_q)
            IDLE: begin
                if (bus.inicio) begin
                    tablero_d  = bus.matriz_entrada;
                    original_d = bus.matriz_entrada;
                    dir_d      = bus.direccion;
                end
            end
            CARGA:    puntos_d = '0;
            PROCESAR: begin
                puntos_d = puntos_q + puntos_linea_w;
                for (int i = 0; i < TAM; i++) begin
                    case (dir_q)
                        DIR_IZQ: tablero_d[k_q][i]       = linea_res_w[i];
                        DIR_DER: tablero_d[k_q][TAM-1-i] = linea_res_w[i];
                        DIR_ARR: tablero_d[i][k_q]       = linea_res_w[i];
                        DIR_ABA: tablero_d[TAM-1-i][k_q] = linea_res_w[i];
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        movido_w = 1'b0;
        gano_w   = 1'b0;
        for (int f = 0; f < TAM; f++) begin
            for (int c = 0; c < TAM; c++) begin
                if (tablero_q[f][c] != original_q[f][c]) movido_w = 1'b1;
                if (tablero_q[f][c] >= META)             gano_w   = 1'b1;
            end
        end
        sel_w = movido_w ? dir_q : DIR_NADA;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q     <= IDLE;
            k_q          <= '0;
            dir_q        <= DIR_NADA;
            tablero_q    <= '{default: 0};
            original_q   <= '{default: 0};
            puntos_q     <= '0;
            res_q        <= '{default: 0};
            sel_q        <= DIR_NADA;
            movido_q     <= 1'b0;
            gano_q       <= 1'b0;
            puntos_out_q <= '0;
        end else begin
            estado_q   <= estado_d;
            k_q        <= k_d;
            dir_q      <= dir_d;
            tablero_q  <= tablero_d;
            original_q <= original_d;
            puntos_q   <= puntos_d;
            if (estado_q == FIN) begin
                res_q        <= tablero_q;
                sel_q        <= sel_w;
                movido_q     <= movido_w;
                gano_q       <= gano_w;
                puntos_out_q <= puntos_q;
            end
        end
    end

    // Results are visible live during FIN, then held from the committed copy
    always_comb begin
        bus.listo   = (estado_q == FIN);
        bus.ocupado = (estado_q == CARGA) || (estado_q == PROCESAR);
        if (estado_q == FIN) begin
            bus.matriz_resultante = tablero_q;
            bus.selector          = sel_w;
            bus.movido            = movido_w;
            bus.gano              = gano_w;
            bus.puntos            = puntos_q;
        end else begin
            bus.matriz_resultante = res_q;
            bus.selector          = sel_q;
            bus.movido            = movido_q;
            bus.gano              = gano_q;
            bus.puntos            = puntos_out_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mover_tablero.sv
// ============================================================
//  tb_mover_tablero : vector table + scoreboard for mover_tablero
//  Rev 1.0
// ============================================================
`default_nettype none

module tb_mover_tablero;
    import juego_pkg::*;

    typedef struct {
        logic [2:0] dir;
        tablero_t   ent;
        tablero_t   sal;
        int         pts;
        logic       mov;
        logic [2:0] sel;
        logic       gano;
        int         lat;
        int         t0;
    } vec_t;

    logic clk;
    logic rst_n;
    int   ciclo;
    int   n_vec;
    int   n_err;
    int   n_listo;
    vec_t sb [$];
    vec_t tabla [8];
    vec_t e_mon;
    int   malas_mon;

    mover_tablero_if bus ();

    mover_tablero #(.TAM(4), .META(2048)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ciclo = 0;
    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
        n_vec++;
        if (act !== esp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nombre, act, esp);
        end
    endtask

    function automatic int celdas_distintas(input tablero_t esp);
        int m = 0;
        for (int f = 0; f < 4; f++)
            for (int c = 0; c < 4; c++)
                if (bus.matriz_resultante[f][c] !== esp[f][c]) m++;
        return m;
    endfunction

    // Scoreboard side: every listo pops one expected move
    always @(negedge clk) begin
        if (rst_n && bus.listo) begin
            n_listo++;
            if (sb.size() == 0) begin
                chk("listo_inesperado", 32'd1, 32'd0);
            end else begin
                e_mon     = sb.pop_front();
                malas_mon = celdas_distintas(e_mon.sal);
                chk($sformatf("tablero_dir%0d", e_mon.dir), malas_mon, 0);
                chk($sformatf("puntos_dir%0d", e_mon.dir), bus.puntos, e_mon.pts);
                chk($sformatf("movido_dir%0d", e_mon.dir), bus.movido, e_mon.mov);
                chk($sformatf("selector_dir%0d", e_mon.dir), bus.selector, e_mon.sel);
                chk($sformatf("gano_dir%0d", e_mon.dir), bus.gano, e_mon.gano);
                chk($sformatf("latencia_dir%0d", e_mon.dir), ciclo - e_mon.t0, e_mon.lat);
                chk($sformatf("ocupado_en_fin_dir%0d", e_mon.dir), bus.ocupado, 1'b0);
            end
        end
    end

    // Called at posedge+1 with the DUT idle; scrambles the inputs once latched
    task automatic aplicar(input vec_t v, input bit esperar);
        vec_t e;
        e    = v;
        e.t0 = ciclo;
        bus.matriz_entrada = v.ent;
        bus.direccion      = v.dir;
        bus.inicio         = 1'b1;
        if (esperar) sb.push_back(e);
        @(posedge clk); #1;
        bus.inicio    = 1'b0;
        bus.direccion = 3'b010;
        for (int f = 0; f < 4; f++)
            for (int c = 0; c < 4; c++)
                bus.matriz_entrada[f][c] = 64;
    endtask

    task automatic esperar_cola();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("cola_pendiente", sb.size(), 0);
        sb.delete();
    endtask

    task automatic chk_reposo(input string pre);
        chk({pre, "_listo"}, bus.listo, 1'b0);
        chk({pre, "_ocupado"}, bus.ocupado, 1'b0);
        chk({pre, "_selector"}, bus.selector, 3'b111);
        chk({pre, "_movido"}, bus.movido, 1'b0);
        chk({pre, "_gano"}, bus.gano, 1'b0);
        chk({pre, "_puntos"}, bus.puntos, 0);
        chk({pre, "_tablero"}, celdas_distintas('{default: 0}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int antes;
        n_vec   = 0;
        n_err   = 0;
        n_listo = 0;

        tabla[0] = '{dir: DIR_IZQ,
            ent: '{'{2,2,2,2}, '{4,0,4,8}, '{0,0,0,2}, '{2,4,8,16}},
            sal: '{'{4,4,0,0}, '{8,8,0,0}, '{2,0,0,0}, '{2,4,8,16}},
            pts: 16, mov: 1'b1, sel: 3'b001, gano: 1'b0, lat: 6, t0: 0};
        tabla[1] = '{dir: DIR_ABA,
            ent: '{'{2,0,0,0}, '{0,0,0,0}, '{2,0,0,0}, '{4,0,0,0}},
            sal: '{'{0,0,0,0}, '{0,0,0,0}, '{4,0,0,0}, '{4,0,0,0}},
            pts: 4, mov: 1'b1, sel: 3'b100, gano: 1'b0, lat: 6, t0: 0};
        tabla[2] = '{dir: DIR_DER,
            ent: '{'{0,0,2,4}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}},
            sal: '{'{0,0,2,4}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}},
            pts: 0, mov: 1'b0, sel: 3'b111, gano: 1'b0, lat: 6, t0: 0};
        tabla[3] = '{dir: DIR_ARR,
            ent: '{'{0,1024,0,0}, '{0,1024,0,0}, '{0,0,0,0}, '{0,0,0,0}},
            sal: '{'{0,2048,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}},
            pts: 2048, mov: 1'b1, sel: 3'b011, gano: 1'b1, lat: 6, t0: 0};
        tabla[4] = '{dir: 3'b110,
            ent: '{'{2,2,0,0}, '{0,0,0,0}, '{0,0,4,4}, '{0,0,0,4096}},
            sal: '{'{2,2,0,0}, '{0,0,0,0}, '{0,0,4,4}, '{0,0,0,4096}},
            pts: 0, mov: 1'b0, sel: 3'b111, gano: 1'b1, lat: 2, t0: 0};
        tabla[5] = '{dir: DIR_DER,
            ent: '{'{2,2,4,4}, '{8,0,0,8}, '{2,4,2,4}, '{0,2,0,0}},
            sal: '{'{0,0,4,8}, '{0,0,0,16}, '{2,4,2,4}, '{0,0,0,2}},
            pts: 28, mov: 1'b1, sel: 3'b010, gano: 1'b0, lat: 6, t0: 0};
        tabla[6] = '{dir: DIR_ARR,
            ent: '{'{0,0,4,2}, '{0,0,4,0}, '{0,0,4,0}, '{2,0,0,2}},
            sal: '{'{2,0,8,4}, '{0,0,4,0}, '{0,0,0,0}, '{0,0,0,0}},
            pts: 12, mov: 1'b1, sel: 3'b011, gano: 1'b0, lat: 6, t0: 0};
        tabla[7] = '{dir: 3'b000,
            ent: '{'{2,2,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}},
            sal: '{'{2,2,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}},
            pts: 0, mov: 1'b0, sel: 3'b111, gano: 1'b0, lat: 2, t0: 0};

        rst_n          = 1'b0;
        bus.inicio     = 1'b0;
        bus.direccion  = 3'b000;
        bus.matriz_entrada = '{default: 0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reposo("reset_inicial");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            aplicar(tabla[v], 1'b1);
            esperar_cola();
        end

        // Reset asserted during the second PROCESAR cycle aborts the move
        antes = n_listo;
        aplicar(tabla[5], 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ocupado_antes_reset", bus.ocupado, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reposo("reset_en_movimiento");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("listo_tras_reset", n_listo - antes, 0);

        // Second inicio while busy must be ignored
        antes = n_listo;
        aplicar(tabla[0], 1'b1);
        @(posedge clk); #1;
        chk("ocupado_durante_mov", bus.ocupado, 1'b1);
        bus.inicio    = 1'b1;
        bus.direccion = DIR_ABA;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        esperar_cola();
        repeat (10) @(posedge clk);
        #1;
        chk("pulsos_listo", n_listo - antes, 1);

        // Outputs hold after the move completes
        @(negedge clk);
        chk("retencion_tablero", celdas_distintas(tabla[0].sal), 0);
        chk("retencion_puntos", bus.puntos, 16);
        chk("retencion_selector", bus.selector, 3'b001);
        chk("retencion_listo", bus.listo, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
